updown_sequencer: RTL and testbench

- Parametrised bidirectional state sequencer: a registered state index steps up or down one position per enabled clock and is decoded to a WIDTH-bit output code.
- Supported codes: binary, Gray, Johnson or one-hot.
- Adds enable, synchronous load, wrap-or-saturate end behaviour, a wrap pulse and an end-of-sequence flag.
- Used as the generic pattern/phase generator for LED chasers, stepper phase tables and display scanning in the lab designs.

---
 rtl/updown_sequencer.sv | 108 ++++++++++
 tb/tb_updown_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/updown_sequencer.sv
// Bidirectional state sequencer: a registered index steps up/down modulo N and
// is decoded to a binary, Gray, Johnson or one-hot output code.
module updown_sequencer #(
    parameter int WIDTH = 3,
    parameter int MODE  = 1,
    parameter int WRAP  = 1,
    parameter int IDXW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [IDXW-1:0]   load_idx,
    output logic [WIDTH-1:0]  out,
    output logic [IDXW-1:0]   idx,
    output logic              wrap,
    output logic              at_end
);

    localparam int N = (MODE == 0 || MODE == 1) ? (1 << WIDTH) :
                       (MODE == 2)              ? (2 * WIDTH)  : WIDTH;

    generate
        if (WIDTH < 2 || WIDTH > 8 || MODE < 0 || MODE > 3 ||
            (WRAP != 0 && WRAP != 1) || IDXW < $clog2(N) || IDXW > 16) begin : g_param_check
            $error("updown_sequencer: illegal WIDTH/MODE/WRAP/IDXW combination");
        end
    endgenerate

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
    localparam logic [IDXW:0]   NLEN = (IDXW + 1)'(N);

    logic [IDXW-1:0]  idx_q;
    logic [IDXW-1:0]  idx_n;
    logic             wrap_q;
    logic             wrap_n;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] bin;
    int unsigned      k;

    // N is not a power of two for Johnson/one-hot, so ends are compared explicitly
    always_comb begin
        idx_n  = idx_q;
        wrap_n = 1'b0;
        if (load) begin
            idx_n = ({1'b0, load_idx} < NLEN) ? load_idx : LAST;
        end else if (en) begin
            if (dir) begin
                if (idx_q == LAST) begin
                    if (WRAP == 1) begin
                        idx_n  = '0;
                        wrap_n = 1'b1;
                    end
                end else begin
                    idx_n = idx_q + 1'b1;
                end
            end else begin
                if (idx_q == '0) begin
                    if (WRAP == 1) begin
                        idx_n  = LAST;
                        wrap_n = 1'b1;
                    end
                end else begin
                    idx_n = idx_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_n;
            wrap_q <= wrap_n;
        end
    end

    always_comb begin
        out_c = '0;
        bin   = WIDTH'(idx_q);
        k     = 32'(idx_q);
        case (MODE)
            0: out_c = bin;
            1: out_c = bin ^ (bin >> 1);
            2: begin
                // Johnson: fill ones from LSB, then clear them from LSB
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (k <= WIDTH) out_c[i] = (i < k);
                    else            out_c[i] = (i >= k - WIDTH);
                end
            end
            default: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    out_c[i] = (k == i);
                end
            end
        endcase
    end

    assign out    = out_c;
    assign idx    = idx_q;
    assign wrap   = wrap_q;
    assign at_end = dir ? (idx_q == LAST) : (idx_q == '0);

endmodule

// File: tb/tb_updown_sequencer.sv
// Runs six sequencer configurations on shared stimulus and compares each one
// every cycle against a behavioural model of the index/code rules.
module tb_updown_sequencer;

    logic       clk = 1'b0;
    logic       rst, en, dir, load;
    logic [3:0] load_idx;

    logic [2:0] out0, out1, out2, out3;
    logic [3:0] out4;
    logic [1:0] out5;
    logic [3:0] ix [6];
    logic       wr [6];
    logic       ae [6];

    int cfg_w    [6] = '{3, 3, 3, 3, 4, 2};
    int cfg_mode [6] = '{1, 2, 0, 3, 2, 3};
    int cfg_wrap [6] = '{1, 1, 0, 1, 0, 1};

    int m_idx  [6];
    int m_wrap [6];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_sequencer #(.WIDTH(3), .MODE(1), .WRAP(1), .IDXW(4)) u0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .out(out0), .idx(ix[0]), .wrap(wr[0]), .at_end(ae[0]));
    updown_sequencer #(.WIDTH(3), .MODE(2), .WRAP(1), .IDXW(4)) u1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .out(out1), .idx(ix[1]), .wrap(wr[1]), .at_end(ae[1]));
    updown_sequencer #(.WIDTH(3), .MODE(0), .WRAP(0), .IDXW(4)) u2 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .out(out2), .idx(ix[2]), .wrap(wr[2]), .at_end(ae[2]));
    updown_sequencer #(.WIDTH(3), .MODE(3), .WRAP(1), .IDXW(4)) u3 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .out(out3), .idx(ix[3]), .wrap(wr[3]), .at_end(ae[3]));
    updown_sequencer #(.WIDTH(4), .MODE(2), .WRAP(0), .IDXW(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .out(out4), .idx(ix[4]), .wrap(wr[4]), .at_end(ae[4]));
    updown_sequencer #(.WIDTH(2), .MODE(3), .WRAP(1), .IDXW(4)) u5 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
        .out(out5), .idx(ix[5]), .wrap(wr[5]), .at_end(ae[5]));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int seq_len(input int i);
        case (cfg_mode[i])
            0, 1:    return 1 << cfg_w[i];
            2:       return 2 * cfg_w[i];
            default: return cfg_w[i];
        endcase
    endfunction

    function automatic int code_of(input int i, input int k);
        int w = cfg_w[i];
        case (cfg_mode[i])
            0: return k;
            1: return k ^ (k >> 1);
            2: return (k <= w) ? ((1 << k) - 1) : (((1 << w) - 1) & ~((1 << (k - w)) - 1));
            default: return 1 << k;
        endcase
    endfunction

    function automatic int dut_out(input int i);
        case (i)
            0: return int'(out0);
            1: return int'(out1);
            2: return int'(out2);
            3: return int'(out3);
            4: return int'(out4);
            default: return int'(out5);
        endcase
    endfunction

    // One clock: apply inputs, advance the model at the edge, compare just after it.
    task automatic cycle(input logic r, input logic e, input logic d,
                         input logic l, input int li);
        @(negedge clk);
        rst = r; en = e; dir = d; load = l; load_idx = 4'(li);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            int n = seq_len(i);
            m_wrap[i] = 0;
            if (r) begin
                m_idx[i] = 0;
            end else if (l) begin
                m_idx[i] = (li < n) ? li : n - 1;
            end else if (e) begin
                if (d) begin
                    if (m_idx[i] < n - 1) m_idx[i] = m_idx[i] + 1;
                    else if (cfg_wrap[i] == 1) begin m_idx[i] = 0; m_wrap[i] = 1; end
                end else begin
                    if (m_idx[i] > 0) m_idx[i] = m_idx[i] - 1;
                    else if (cfg_wrap[i] == 1) begin m_idx[i] = n - 1; m_wrap[i] = 1; end
                end
            end
        end
        #1;
        for (int i = 0; i < 6; i++) begin
            int n = seq_len(i);
            check($sformatf("u%0d.idx", i),    int'(ix[i]), m_idx[i]);
            check($sformatf("u%0d.out", i),    dut_out(i), code_of(i, m_idx[i]));
            check($sformatf("u%0d.wrap", i),   int'(wr[i]), m_wrap[i]);
            check($sformatf("u%0d.at_end", i), int'(ae[i]),
                  (d ? (m_idx[i] == n - 1) : (m_idx[i] == 0)) ? 1 : 0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_idx = '0;
        for (int i = 0; i < 6; i++) begin
            m_idx[i] = 0;
            m_wrap[i] = 0;
        end

        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        // full upward pass, wrapping the Gray and smaller sequences
        for (int c = 0; c < 9; c++) cycle(0, 1, 1, 0, 0);
        // downward from reset: Johnson wraps to idx 5 first
        cycle(1, 0, 0, 0, 0);
        for (int c = 0; c < 7; c++) cycle(0, 1, 0, 0, 0);
        // load 6, step up against the saturating end, then step back down
        cycle(0, 0, 1, 1, 6);
        for (int c = 0; c < 4; c++) cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        // out-of-range load clamps; load beats en
        cycle(0, 0, 1, 1, 9);
        cycle(0, 1, 1, 1, 0);
        // dir flips every cycle from idx 0, then hold
        for (int c = 0; c < 6; c++) cycle(0, 1, c[0], 0, 0);
        for (int c = 0; c < 3; c++) cycle(0, 0, 1, 0, 0);
        // reset overrides load and en mid-sequence, then stepping resumes
        cycle(0, 0, 1, 1, 5);
        cycle(1, 1, 1, 1, 3);
        for (int c = 0; c < 3; c++) cycle(0, 1, 1, 0, 0);

        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
